prog_fetch_exec: RTL and testbench
==================================

Name: prog_fetch_exec

Overview:
Reads the 16-entry, 16-bit combinational program ROM and executes its instructions. Contains the program counter, instruction register, a fetch/decode/execute FSM, an 8x8 register file and a registered output port. It is the consumer side of the ROM interface: it drives the ROM address and captures the returned instruction word.

Parameters:
ADDR_W, 4, ROM address width; PC wraps modulo 2^ADDR_W.
DATA_W, 8, register-file and output data width.
NREGS, 8, register-file depth, indexed by a 3-bit field.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  level; when high, the FSM may leave FETCH.
rom_addr  out  ADDR_W  ROM address, always equal to pc.
rom_data  in  16  ROM instruction word, combinational from rom_addr.
out_data  out  DATA_W  last value emitted by OUT.
out_valid  out  1  one-cycle pulse when out_data is updated.
illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
pc_dbg  out  ADDR_W  current pc.
state_dbg  out  2  current FSM state encoding.

Behaviour:
- Instruction fields: op = [15:12], rd = [11:9], rs = [8:6], imm8 = [7:0], jaddr = [ADDR_W-1:0].
- Opcodes:
  - 0000 NOP.
  - 0001 LOAD: r[rd] <= imm8.
  - 0010 ADD: r[rd] <= r[rd] + r[rs], modulo 2^DATA_W; no carry is kept.
  - 1100 JMP: pc <= jaddr.
  - 1111 OUT: out_data <= r[rd].
  - Every other opcode executes as a NOP and pulses illegal.
- Reset: pc=0, ir=0, all registers=0, out_data=0, out_valid=0, illegal=0, state=FETCH.
- FSM states and encodings: FETCH=00, DECODE=01, EXEC=10. Each instruction takes exactly 3 cycles.
  - FETCH: if run=1, ir <= rom_data and go to DECODE; otherwise stay in FETCH and hold all state.
  - DECODE: latch operand A = r[rd], operand B = r[rs], and the decoded op; go to EXEC.
  - EXEC: perform the write-back, OUT or JMP. pc <= jaddr for JMP, else pc + 1 (wrapping 15 -> 0). Go to FETCH.
- Timing of results:
  - out_valid and illegal are high only during the cycle after EXEC, i.e. registered at the EXEC edge.
  - The register write is visible to the next instruction's DECODE.
- ADD with rd == rs doubles the register, since both operands are read in DECODE before the write.
- JMP to the address of the JMP itself loops forever, 3 cycles per iteration; this is legal.
- run deasserted mid-instruction: the current instruction completes, and the FSM then holds in FETCH. run is sampled only in FETCH.
- rst asserted in any state overrides all other activity that cycle. Any in-flight register write or OUT is dropped.
- rom_addr is registered (equals pc) and never glitches mid-cycle.

Decomposition:
- Shared package holds:
  - opcode constants: OP_NOP, OP_LOAD, OP_ADD, OP_JMP, OP_OUT;
  - field bit positions;
  - FSM state encodings.
- One sub-module: prog_regfile. It has 8 x DATA_W storage, two asynchronous read ports (rd, rs), one synchronous write port, and synchronous reset to zero.
- The FSM, pc, ir and output register stay in prog_fetch_exec.

Test Plan:
1. Reset then run=1 with ROM = [LOAD r1,2; ADD r1,r1; OUT r1; JMP 0] -> out_valid pulses at cycle 9 after reset release with out_data=0x04. It then pulses every 12 cycles with out_data=0x04.
2. LOAD r5,0xFF; ADD r5,r5; OUT r5 -> out_data=0xFE (wrap, carry discarded).
3. run held low for 10 cycles after reset -> pc_dbg=0 and state_dbg=FETCH throughout. When run rises, the first fetch completes on the next edge.
4. Opcode 0101 at address 3 -> illegal pulses once, registers are unchanged, and pc advances to 4.
5. NOP at address 15 with no JMP -> pc wraps to 0 and execution resumes at the first instruction.
6. rst asserted during the EXEC of an OUT -> no out_valid pulse, out_data=0, pc=0 and state=FETCH on the next cycle.

Source files
------------

// File: rtl/prog_fetch_exec_pkg.sv
// Shared definitions for the fetch/decode/execute core: opcodes, instruction
// field positions and FSM state encodings.
package prog_fetch_exec_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_LOAD) || (op == OP_ADD) ||
               (op == OP_JMP) || (op == OP_OUT);
    endfunction

endpackage

// File: rtl/prog_regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one synchronous
// write port, synchronous clear on rst.
module prog_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/prog_fetch_exec.sv
// Three-cycle fetch/decode/execute core reading a combinational program ROM,
// with pc, instruction register, operand latches and a registered output port.
module prog_fetch_exec
    import prog_fetch_exec_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [1:0]        state_dbg
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              illegal_q, illegal_d;

    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    prog_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (ir_q[RD_HI:RD_LO]),
        .wdata   (rf_wdata),
        .raddr_a (ir_q[RD_HI:RD_LO]),
        .raddr_b (ir_q[RS_HI:RS_LO]),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    // ir still holds the executing instruction during EXEC, so rd and imm8
    // come straight from it; only the operands needed latching in DECODE.
    always_comb begin
        rf_we    = (state_q == ST_EXEC) && ((op_q == OP_LOAD) || (op_q == OP_ADD));
        rf_wdata = (op_q == OP_LOAD) ? DATA_W'(ir_q[IMM_HI:IMM_LO]) : (opa_q + opb_q);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_d    = rom_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d    = ir_q[OP_HI:OP_LO];
                opa_d   = rf_rdata_a;
                opb_d   = rf_rdata_b;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d = (op_q == OP_JMP) ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
                if (op_q == OP_OUT) begin
                    out_data_d  = opa_q;
                    out_valid_d = 1'b1;
                end
                illegal_d = !op_is_legal(op_q);
                state_d   = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            op_q        <= OP_NOP;
            opa_q       <= '0;
            opb_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign rom_addr  = pc_q;
    assign pc_dbg    = pc_q;
    assign state_dbg = state_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_prog_fetch_exec.sv
// Self-checking bench for prog_fetch_exec: table-driven program scenarios plus
// cycle-exact hand sequences for timing, run gating and reset corner cases.
module tb_prog_fetch_exec;
    import prog_fetch_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        illegal;
    logic [3:0]  pc_dbg;
    logic [1:0]  state_dbg;

    logic [15:0] rom [16];

    int tests_run    = 0;
    int tests_failed = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    prog_fetch_exec dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .illegal   (illegal),
        .pc_dbg    (pc_dbg),
        .state_dbg (state_dbg)
    );

    typedef struct {
        logic [15:0][15:0] prog;
        int                cycles;
        logic [3:0]        exp_pc;
        logic [1:0]        exp_state;
        logic [7:0]        exp_out;
        int                exp_nout;
        int                exp_nill;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] i_load(input logic [2:0] rd, input logic [7:0] imm);
        return {OP_LOAD, rd, 1'b0, imm};
    endfunction

    function automatic logic [15:0] i_add(input logic [2:0] rd, input logic [2:0] rs);
        return {OP_ADD, rd, rs, 6'b0};
    endfunction

    function automatic logic [15:0] i_out(input logic [2:0] rd);
        return {OP_OUT, rd, 9'b0};
    endfunction

    function automatic logic [15:0] i_jmp(input logic [3:0] a);
        return {OP_JMP, 8'b0, a};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    task automatic loadRom(input logic [15:0][15:0] p);
        for (int i = 0; i < 16; i++) begin
            rom[i] = p[i];
        end
    endtask

    task automatic doReset;
        rst = 1'b1;
        run = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, output int nout, output int nill);
        nout = 0;
        nill = 0;
        loadRom(vecs[idx].prog);
        doReset();
        run = 1'b1;
        for (int c = 0; c < vecs[idx].cycles; c++) begin
            tick();
            if (out_valid === 1'b1) nout++;
            if (illegal === 1'b1) nill++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nout;
        int nill;
        logic [15:0][15:0] p;

        // Scenario table: program, cycles to run, expected end state and counts.
        for (int v = 0; v < 6; v++) vecs[v].prog = '0;

        vecs[0].prog[0] = i_load(3'd5, 8'hFF);
        vecs[0].prog[1] = i_add(3'd5, 3'd5);
        vecs[0].prog[2] = i_out(3'd5);
        vecs[0].prog[3] = i_jmp(4'd3);
        vecs[0].cycles = 30; vecs[0].exp_pc = 4'd3; vecs[0].exp_state = 2'b00;
        vecs[0].exp_out = 8'hFE; vecs[0].exp_nout = 1; vecs[0].exp_nill = 0;

        vecs[1].prog[0] = i_load(3'd2, 8'h33);
        vecs[1].prog[3] = 16'h5400;
        vecs[1].prog[4] = i_out(3'd2);
        vecs[1].prog[5] = i_jmp(4'd5);
        vecs[1].cycles = 12; vecs[1].exp_pc = 4'd4; vecs[1].exp_state = 2'b00;
        vecs[1].exp_out = 8'h00; vecs[1].exp_nout = 0; vecs[1].exp_nill = 1;

        vecs[2] = vecs[1];
        vecs[2].cycles = 18; vecs[2].exp_pc = 4'd5;
        vecs[2].exp_out = 8'h33; vecs[2].exp_nout = 1; vecs[2].exp_nill = 1;

        vecs[3].prog[0] = i_load(3'd4, 8'h01);
        vecs[3].prog[1] = i_add(3'd3, 3'd4);
        vecs[3].prog[2] = i_out(3'd3);
        vecs[3].cycles = 48; vecs[3].exp_pc = 4'd0; vecs[3].exp_state = 2'b00;
        vecs[3].exp_out = 8'h01; vecs[3].exp_nout = 1; vecs[3].exp_nill = 0;

        vecs[4] = vecs[3];
        vecs[4].cycles = 57; vecs[4].exp_pc = 4'd3;
        vecs[4].exp_out = 8'h02; vecs[4].exp_nout = 2;

        vecs[5].prog[0] = i_load(3'd1, 8'h30);
        vecs[5].prog[1] = i_load(3'd2, 8'h45);
        vecs[5].prog[2] = i_add(3'd1, 3'd2);
        vecs[5].prog[3] = i_out(3'd1);
        vecs[5].prog[4] = i_jmp(4'd4);
        vecs[5].cycles = 15; vecs[5].exp_pc = 4'd4; vecs[5].exp_state = 2'b00;
        vecs[5].exp_out = 8'h75; vecs[5].exp_nout = 1; vecs[5].exp_nill = 0;

        // Reset values, then the basic program with cycle-exact out_valid timing.
        p = '0;
        p[0] = i_load(3'd1, 8'h02);
        p[1] = i_add(3'd1, 3'd1);
        p[2] = i_out(3'd1);
        p[3] = i_jmp(4'd0);
        loadRom(p);
        doReset();
        checkOutput("reset pc", 32'(pc_dbg), 32'd0);
        checkOutput("reset state", 32'(state_dbg), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset illegal", 32'(illegal), 32'd0);
        checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
        run = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            checkOutput($sformatf("basic out_valid c%0d", c), 32'(out_valid),
                        32'((c == 9) || (c == 21)));
            if ((c == 9) || (c == 21))
                checkOutput($sformatf("basic out_data c%0d", c), 32'(out_data), 32'h04);
            if (c == 12)
                checkOutput("basic pc after jmp", 32'(pc_dbg), 32'd0);
        end

        for (int v = 0; v < 6; v++) begin
            applyStimulus(v, nout, nill);
            checkOutput($sformatf("vec%0d pc", v), 32'(pc_dbg), 32'(vecs[v].exp_pc));
            checkOutput($sformatf("vec%0d state", v), 32'(state_dbg), 32'(vecs[v].exp_state));
            checkOutput($sformatf("vec%0d out_data", v), 32'(out_data), 32'(vecs[v].exp_out));
            checkOutput($sformatf("vec%0d out pulses", v), 32'(nout), 32'(vecs[v].exp_nout));
            checkOutput($sformatf("vec%0d illegal pulses", v), 32'(nill), 32'(vecs[v].exp_nill));
        end

        // run held low: nothing moves; the first fetch lands on the next edge after run rises.
        loadRom(p);
        doReset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            checkOutput($sformatf("idle pc c%0d", c), 32'(pc_dbg), 32'd0);
            checkOutput($sformatf("idle state c%0d", c), 32'(state_dbg), 32'd0);
        end
        run = 1'b1;
        tick();
        checkOutput("idle first fetch state", 32'(state_dbg), 32'd1);

        // run dropped after the fetch: the instruction completes, then FETCH holds.
        doReset();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        checkOutput("run drop pc", 32'(pc_dbg), 32'd1);
        checkOutput("run drop state", 32'(state_dbg), 32'd0);
        for (int c = 0; c < 5; c++) tick();
        checkOutput("run drop hold pc", 32'(pc_dbg), 32'd1);
        checkOutput("run drop hold state", 32'(state_dbg), 32'd0);

        // Reset landing on the EXEC edge of an OUT drops the output.
        p = '0;
        p[0] = i_load(3'd1, 8'h02);
        p[1] = i_out(3'd1);
        p[2] = i_jmp(4'd0);
        loadRom(p);
        doReset();
        run = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checkOutput("rst-in-exec pre state", 32'(state_dbg), 32'd2);
        rst = 1'b1;
        tick();
        checkOutput("rst-in-exec out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst-in-exec out_data", 32'(out_data), 32'd0);
        checkOutput("rst-in-exec pc", 32'(pc_dbg), 32'd0);
        checkOutput("rst-in-exec state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        run = 1'b0;
        tick();
        checkOutput("rst-in-exec after out_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
